dff_share_arbiter: RTL

Round-robin arbiter that shares one `BITS_COUNT`-wide storage register, equivalent to the `dff` stage, among `N_REQ` requesters. Each requester offers a word over a valid/ready handshake. The arbiter picks one winner per cycle, loads the winner's word into the register, and presents it downstream over a second valid/ready handshake with the source index attached. It sits between several producers and a single consumer in place of a bare `dff`, and keeps a running count of accepted transfers.

---
 rtl/dff_share_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that funnels N_REQ valid/ready producers into one shared
// output register, tagging each held word with its source index.

package dffx;
  parameter int dff_bits_count = 8;
endpackage

module dff_share_arbiter #(
  parameter int BITS_COUNT = dffx::dff_bits_count,
  parameter int N_REQ      = 4,
  parameter int COUNT_BITS = 16,
  localparam int SRC_BITS  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*BITS_COUNT-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [BITS_COUNT-1:0]       out_data,
  output logic [SRC_BITS-1:0]         out_src,
  input  logic                        out_ready,
  output logic [COUNT_BITS-1:0]       xfer_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_can_load;
  logic                  w_found;
  logic                  w_load;
  logic [SRC_BITS-1:0]   w_winner;
  logic [SRC_BITS-1:0]   w_cand;
  logic [SRC_BITS-1:0]   r_last_grant;
  logic [SRC_BITS-1:0]   r_src;
  logic [BITS_COUNT-1:0] w_win_data;
  logic [BITS_COUNT-1:0] r_data;
  logic [COUNT_BITS-1:0] r_count;

  // Search starts one past the last grant, so the previous winner is tried last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = SRC_BITS'((int'(r_last_grant) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end else begin
        w_found  = w_found;
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == SRC_BITS'(i)) begin
        w_win_data = req_data[i*BITS_COUNT +: BITS_COUNT];
      end else begin
        w_win_data = w_win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_load) w_state_nxt = ST_FULL;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_load)         w_state_nxt = ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
        else                w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // reset_n only masks the handshake output so no flop sees it as data.
  always_comb begin
    w_can_load = (r_state == ST_EMPTY) | out_ready;
    w_load     = w_can_load & w_found;
    out_valid  = (r_state == ST_FULL);
    req_ready  = '0;
    if (w_load) begin
      req_ready[w_winner] = reset_n;
    end else begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= '0;
      r_src        <= '0;
      r_last_grant <= SRC_BITS'(N_REQ - 1);
      r_count      <= '0;
    end else if (w_load) begin
      r_data       <= w_win_data;
      r_src        <= w_winner;
      r_last_grant <= w_winner;
      r_count      <= r_count + COUNT_BITS'(1);
    end else begin
      r_data       <= r_data;
      r_src        <= r_src;
      r_last_grant <= r_last_grant;
      r_count      <= r_count;
    end
  end

  assign out_data   = r_data;
  assign out_src    = r_src;
  assign xfer_count = r_count;

endmodule
